// File: rtl/ysyx_23060208_ifu.sv
// rtl/ysyx_23060208_ifu.sv - instruction fetch stage, one instruction in flight over AXI-lite AR/R.
// Optional macro IFU_RRESP_CHECK_EN: substitute ebreak for the fetched word on a non-OKAY read response.
module ysyx_23060208_ifu #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH:0]       exu_to_ifu_bus,
  input  logic                      exu_to_ifu_valid,
  output logic [DATA_WIDTH-1:0]     isram_araddr,
  output logic                      isram_arvalid,
  input  logic                      isram_arready,
  input  logic [DATA_WIDTH-1:0]     isram_rdata,
  input  logic [1:0]                isram_rresp,
  input  logic                      isram_rvalid,
  output logic                      isram_rready,
  output logic                      ifu_done,
  output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
  output logic                      ifu_to_idu_valid,
  input  logic                      idu_allowin
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_AR,
    S_R,
    S_HOLD,
    S_WAIT_EXU
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0] inst_q;
  logic [DATA_WIDTH-1:0] inst_d;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  valid_q;

  always_comb begin
    pc_d = exu_to_ifu_bus[DATA_WIDTH] ? exu_to_ifu_bus[DATA_WIDTH-1:0]
                                      : pc_q + DATA_WIDTH'(4);
  end

`ifdef IFU_RRESP_CHECK_EN
  // A faulted fetch becomes ebreak so the simulator traps at the offending pc.
  always_comb begin
    inst_d = (isram_rresp != 2'b00) ? DATA_WIDTH'(32'h0010_0073) : isram_rdata;
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^isram_rresp;

  always_comb begin
    inst_d = isram_rdata;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          arvalid_q <= 1'b1;
          state_q   <= S_AR;
        end
        S_AR: begin
          if (isram_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (isram_rvalid) begin
            inst_q   <= inst_d;
            rready_q <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (idu_allowin) begin
            valid_q <= 1'b0;
            state_q <= S_WAIT_EXU;
          end
        end
        S_WAIT_EXU: begin
          if (exu_to_ifu_valid) begin
            pc_q      <= pc_d;
            arvalid_q <= 1'b1;
            state_q   <= S_AR;
          end
        end
        default: begin
          state_q   <= S_BOOT;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  // rready is only ever high in R, so this is exactly the R handshake.
  assign ifu_done         = rready_q & isram_rvalid;
  assign isram_araddr     = pc_q;
  assign isram_arvalid    = arvalid_q;
  assign isram_rready     = rready_q;
  assign ifu_to_idu_valid = valid_q;
  assign ifu_to_idu_bus   = {pc_q, inst_q};

endmodule

// File: tb/tb_ysyx_23060208_ifu.sv
// tb/tb_ysyx_23060208_ifu.sv - randomized self-checking bench for ysyx_23060208_ifu.
module tb_ysyx_23060208_ifu;

  logic        clk;
  logic        rst;
  logic [32:0] exu_to_ifu_bus;
  logic        exu_to_ifu_valid;
  logic [31:0] isram_araddr;
  logic        isram_arvalid;
  logic        isram_arready;
  logic [31:0] isram_rdata;
  logic [1:0]  isram_rresp;
  logic        isram_rvalid;
  logic        isram_rready;
  logic        ifu_done;
  logic [63:0] ifu_to_idu_bus;
  logic        ifu_to_idu_valid;
  logic        idu_allowin;

  int total;
  int bad;

  // Reference model: the address the IFU must fetch next.
  logic [31:0] m_pc;

  ysyx_23060208_ifu dut (
    .clk              (clk),
    .rst              (rst),
    .exu_to_ifu_bus   (exu_to_ifu_bus),
    .exu_to_ifu_valid (exu_to_ifu_valid),
    .isram_araddr     (isram_araddr),
    .isram_arvalid    (isram_arvalid),
    .isram_arready    (isram_arready),
    .isram_rdata      (isram_rdata),
    .isram_rresp      (isram_rresp),
    .isram_rvalid     (isram_rvalid),
    .isram_rready     (isram_rready),
    .ifu_done         (ifu_done),
    .ifu_to_idu_bus   (ifu_to_idu_bus),
    .ifu_to_idu_valid (ifu_to_idu_valid),
    .idu_allowin      (idu_allowin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expected_inst(input logic [31:0] rdata, input logic [1:0] rresp);
`ifdef IFU_RRESP_CHECK_EN
    return (rresp != 2'b00) ? 32'h0010_0073 : rdata;
`else
    return rdata;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    exu_to_ifu_bus = '0; exu_to_ifu_valid = 1'b0;
    isram_arready = 1'b0; isram_rdata = '0; isram_rresp = 2'b00;
    isram_rvalid = 1'b0; idu_allowin = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (isram_arvalid !== 1'b0 || isram_rready !== 1'b0 || ifu_to_idu_valid !== 1'b0 || ifu_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: arvalid=%b rready=%b valid=%b done=%b required all 0",
               isram_arvalid, isram_rready, ifu_to_idu_valid, ifu_done);
    end
    total++;
    if (ifu_to_idu_bus !== 64'h8000_0000_0000_0000) begin
      bad++;
      $display("FAIL reset_bus: got %h required %h", ifu_to_idu_bus, 64'h8000_0000_0000_0000);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    total++;
    if (isram_arvalid !== 1'b1 || isram_araddr !== 32'h8000_0000) begin
      bad++;
      $display("FAIL boot_first_ar: arvalid=%b araddr=%h required 1 80000000", isram_arvalid, isram_araddr);
    end
    m_pc = 32'h8000_0000;
  endtask

  // One full instruction loop with chosen stall lengths; entered and left in AR.
  task automatic test_fetch_cycle(input int ar_dly, input int r_dly, input int hold_dly, input int exu_dly,
                                  input logic taken, input logic [31:0] nextpc,
                                  input logic [31:0] rdata, input logic [1:0] rresp, input logic spurious);
    logic [31:0] inst_exp;
    for (int i = 0; i <= ar_dly; i++) begin
      total++;
      if (isram_arvalid !== 1'b1 || isram_araddr !== m_pc || isram_rready !== 1'b0) begin
        bad++;
        $display("FAIL ar_phase: arvalid=%b araddr=%h rready=%b required 1 %h 0",
                 isram_arvalid, isram_araddr, isram_rready, m_pc);
      end
      isram_arready = (i == ar_dly);
      isram_rvalid = spurious;
      exu_to_ifu_valid = spurious;
      exu_to_ifu_bus = {1'b1, $urandom()};
      #1;
      total++;
      if (ifu_done !== 1'b0) begin
        bad++;
        $display("FAIL done_in_ar: got %b required 0", ifu_done);
      end
      step();
    end
    isram_arready = 1'b0; isram_rvalid = 1'b0; exu_to_ifu_valid = 1'b0;
    for (int i = 0; i <= r_dly; i++) begin
      total++;
      if (isram_rready !== 1'b1 || isram_arvalid !== 1'b0 || ifu_to_idu_valid !== 1'b0) begin
        bad++;
        $display("FAIL r_phase: rready=%b arvalid=%b valid=%b required 1 0 0",
                 isram_rready, isram_arvalid, ifu_to_idu_valid);
      end
      isram_rvalid = (i == r_dly);
      isram_rdata = (i == r_dly) ? rdata : $urandom();
      isram_rresp = rresp;
      isram_arready = spurious;
      #1;
      total++;
      if (ifu_done !== (i == r_dly)) begin
        bad++;
        $display("FAIL done_pulse: got %b required %b", ifu_done, (i == r_dly));
      end
      step();
    end
    isram_rvalid = 1'b0; isram_arready = 1'b0;
    inst_exp = expected_inst(rdata, rresp);
    for (int i = 0; i <= hold_dly; i++) begin
      total++;
      if (ifu_to_idu_valid !== 1'b1 || ifu_to_idu_bus !== {m_pc, inst_exp} ||
          isram_arvalid !== 1'b0 || isram_rready !== 1'b0) begin
        bad++;
        $display("FAIL hold_phase: valid=%b bus=%h arvalid=%b rready=%b required 1 %h 0 0",
                 ifu_to_idu_valid, ifu_to_idu_bus, isram_arvalid, isram_rready, {m_pc, inst_exp});
      end
      idu_allowin = (i == hold_dly);
      exu_to_ifu_valid = spurious && (i < hold_dly);
      exu_to_ifu_bus = {1'b1, $urandom()};
      isram_rvalid = spurious;
      isram_rdata = $urandom();
      #1;
      total++;
      if (ifu_done !== 1'b0) begin
        bad++;
        $display("FAIL done_in_hold: got %b required 0", ifu_done);
      end
      step();
    end
    idu_allowin = 1'b0; exu_to_ifu_valid = 1'b0; isram_rvalid = 1'b0;
    for (int i = 0; i <= exu_dly; i++) begin
      total++;
      if (ifu_to_idu_valid !== 1'b0 || isram_arvalid !== 1'b0 || isram_rready !== 1'b0) begin
        bad++;
        $display("FAIL wait_exu_phase: valid=%b arvalid=%b rready=%b required 0 0 0",
                 ifu_to_idu_valid, isram_arvalid, isram_rready);
      end
      exu_to_ifu_valid = (i == exu_dly);
      exu_to_ifu_bus = (i == exu_dly) ? {taken, nextpc} : {1'b1, $urandom()};
      isram_rvalid = spurious;
      idu_allowin = spurious;
      step();
    end
    exu_to_ifu_valid = 1'b0; isram_rvalid = 1'b0; idu_allowin = 1'b0;
    m_pc = taken ? nextpc : m_pc + 32'd4;
  endtask

  task automatic test_boot_and_backpressure();
    test_fetch_cycle(0, 0, 0, 0, 1'b0, 32'h0, 32'h0000_0413, 2'b00, 1'b0);
    test_fetch_cycle(0, 0, 5, 0, 1'b0, 32'h0, 32'h0000_0513, 2'b00, 1'b0);
  endtask

  task automatic test_sequential_redirect();
    total++;
    if (isram_araddr !== 32'h8000_0008) begin
      bad++;
      $display("FAIL sequential_pc: got %h required 80000008", isram_araddr);
    end
    test_fetch_cycle(0, 0, 0, 2, 1'b1, 32'h8000_0100, 32'h0000_0013, 2'b00, 1'b1);
    total++;
    if (isram_araddr !== 32'h8000_0100) begin
      bad++;
      $display("FAIL redirect_pc: got %h required 80000100", isram_araddr);
    end
    test_fetch_cycle(1, 1, 1, 1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0093, 2'b00, 1'b0);
    test_fetch_cycle(0, 0, 0, 0, 1'b0, 32'h1234_0000, 32'h0000_0113, 2'b00, 1'b0);
    total++;
    if (isram_araddr !== 32'h0000_0000) begin
      bad++;
      $display("FAIL wrap_pc: got %h required 00000000", isram_araddr);
    end
  endtask

  task automatic test_rresp();
    test_fetch_cycle(0, 0, 0, 0, 1'b0, 32'h0, 32'h1234_5678, 2'b10, 1'b0);
  endtask

  task automatic test_stall_reset();
    test_fetch_cycle(3, 4, 0, 0, 1'b0, 32'h0, 32'h0000_0193, 2'b00, 1'b0);
    isram_arready = 1'b1;
    step();
    isram_arready = 1'b0;
    total++;
    if (isram_rready !== 1'b1) begin
      bad++;
      $display("FAIL stall_reset_in_r: rready=%b required 1", isram_rready);
    end
    isram_rvalid = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (isram_arvalid !== 1'b0 || isram_rready !== 1'b0 || ifu_to_idu_valid !== 1'b0 || ifu_done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: arvalid=%b rready=%b valid=%b done=%b required all 0",
               isram_arvalid, isram_rready, ifu_to_idu_valid, ifu_done);
    end
    isram_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    m_pc = 32'h8000_0000;
    total++;
    if (isram_arvalid !== 1'b1 || isram_araddr !== 32'h8000_0000) begin
      bad++;
      $display("FAIL refetch_after_reset: arvalid=%b araddr=%h required 1 80000000", isram_arvalid, isram_araddr);
    end
  endtask

  task automatic test_random();
    logic        taken;
    logic [31:0] nextpc;
    for (int n = 0; n < 40; n++) begin
      taken = 1'($urandom_range(0, 1));
      nextpc = $urandom() & 32'hFFFF_FFFC;
      test_fetch_cycle($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       taken, nextpc, $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    total++;
    if (isram_arvalid !== 1'b1 || isram_araddr !== m_pc) begin
      bad++;
      $display("FAIL random_final_ar: arvalid=%b araddr=%h required 1 %h", isram_arvalid, isram_araddr, m_pc);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_boot_and_backpressure();
    test_sequential_redirect();
    test_rresp();
    test_stall_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_ifu.md
Name: ysyx_23060208_ifu

Overview:
- Instruction fetch stage. Owns the PC and fetches one instruction at a time from instruction SRAM over an AXI-lite read channel (AR/R only).
- Hands {pc, inst} to IDU through the valid/allowin pipeline handshake.
- Consumes the EXU redirect bus {taken, nextpc} to form the next PC.
- Strictly one instruction in flight: the next fetch waits for the current instruction to retire through EXU. No branch prediction is needed.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- exu_to_ifu_bus  in  33  {nextpc_taken[32], nextpc[31:0]} from EXU
- exu_to_ifu_valid  in  1  EXU finished current instruction; bus valid this cycle
- isram_araddr  out  32  fetch address
- isram_arvalid  out  1  AR valid
- isram_arready  in  1  AR ready
- isram_rdata  in  32  instruction word
- isram_rresp  in  2  read response
- isram_rvalid  in  1  R valid
- isram_rready  out  1  R ready
- ifu_done  out  1  one-cycle pulse on R handshake (to arbiter)
- ifu_to_idu_bus  out  64  {pc[63:32], inst[31:0]}
- ifu_to_idu_valid  out  1  instruction available to IDU
- idu_allowin  in  1  IDU accepts this cycle

Behaviour:
- States: BOOT, AR, R, HOLD, WAIT_EXU.
- Reset values: state=BOOT; pc=RESET_PC; inst_r=0; isram_arvalid=0; isram_rready=0; ifu_to_idu_valid=0; ifu_done=0. Outputs drop to these values immediately on rst=0, even mid-transaction.
- BOOT: one cycle, then AR. First arvalid appears in the 1st cycle after reset deasserts, with araddr=RESET_PC.
- AR:
  - arvalid=1, araddr=pc.
  - Both are held stable until arvalid&&arready.
  - On handshake, go to R.
- R:
  - rready=1.
  - On rvalid&&rready: capture rdata into inst_r, pulse ifu_done for that cycle, go to HOLD next cycle.
  - An rvalid arriving in any state other than R is ignored.
- HOLD:
  - ifu_to_idu_valid=1; bus={pc, inst_r}, held stable.
  - On ifu_to_idu_valid&&idu_allowin, go to WAIT_EXU.
- WAIT_EXU:
  - ifu_to_idu_valid=0.
  - On exu_to_ifu_valid: pc <= nextpc_taken ? nextpc : pc+4, then go to AR.
  - pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
  - A taken nextpc is used unmodified; alignment is EXU's responsibility.
- exu_to_ifu_valid in any state other than WAIT_EXU is ignored, and pc is unchanged.
- arvalid and rready are never high together. ifu_to_idu_valid is high only in HOLD.
- Minimum loop with zero-wait slave and IDU/EXU single-cycle: AR(1) + R(1) + HOLD(1) + WAIT_EXU(>=1) cycles per instruction.

Optional Feature:
- Macro IFU_RRESP_CHECK_EN.
- Defined: when the R handshake carries isram_rresp != 2'b00, inst_r captures 32'h0010_0073 (ebreak) instead of rdata, so the simulator traps on a fetch bus error. pc is unchanged; ifu_done still pulses.
- Undefined: rresp is ignored and rdata is always captured.

Test Plan:
- Reset release with arready=1, rvalid on the next cycle with rdata=32'h0000_0413 -> arvalid=1 and araddr=32'h8000_0000 in cycle 1; ifu_done pulses once; bus=64'h8000_0000_0000_0413 with valid=1.
- Back-pressure: hold idu_allowin=0 for 5 cycles in HOLD -> valid stays 1 and bus is unchanged; no new AR is issued; raise allowin -> valid drops the next cycle.
- Sequential: exu_to_ifu_valid=1 with bus={0, x} at pc=32'h8000_0004 -> next araddr=32'h8000_0008.
- Redirect: exu_to_ifu_valid=1 with bus={1, 32'h8000_0100} -> next araddr=32'h8000_0100. Wrap case: pc=32'hFFFF_FFFC not taken -> araddr=32'h0000_0000.
- Slave stalls: arready low for 3 cycles, then rvalid delayed 4 cycles -> araddr/arvalid stable throughout; rready high only in R; exactly one ifu_done pulse. Assert rst=0 while in R -> arvalid, rready and valid go to 0 immediately; after release, refetch 32'h8000_0000.
- With IFU_RRESP_CHECK_EN: rresp=2'b10 with rdata=32'h1234_5678 -> bus inst=32'h0010_0073. Without the macro -> inst=32'h1234_5678.
